// File: rtl/cdb_pkg.sv
// rtl/cdb_pkg.sv - shared widths, source indices, entry struct and age helper for the CDB arbiter
package cdb_pkg;

  localparam int DATA_W  = 32;
  localparam int TAG_W   = 5;
  localparam int DEST_W  = 5;
  localparam int NUM_SRC = 4;

  localparam logic [1:0] SRC_ALU1 = 2'd0;
  localparam logic [1:0] SRC_ALU2 = 2'd1;
  localparam logic [1:0] SRC_LD1  = 2'd2;
  localparam logic [1:0] SRC_LD2  = 2'd3;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DEST_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } cdb_entry_t;

  // Distance from the commit pointer in ROB order; wraps modulo 2^TAG_W.
  function automatic logic [TAG_W-1:0] cdb_age(input logic [TAG_W-1:0] tag,
                                               input logic [TAG_W-1:0] commit_p);
    return tag - commit_p;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - producer handshake and dual CDB broadcast bundle
interface cdb_arbiter_if;
  import cdb_pkg::*;

  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC*TAG_W-1:0]  src_tag;
  logic [NUM_SRC*DEST_W-1:0] src_dest;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [NUM_SRC-1:0]        src_ready;

  logic              cdb0_valid;
  logic [TAG_W-1:0]  cdb0_tag;
  logic [DEST_W-1:0] cdb0_dest;
  logic [DATA_W-1:0] cdb0_data;
  logic [1:0]        cdb0_src;

  logic              cdb1_valid;
  logic [TAG_W-1:0]  cdb1_tag;
  logic [DEST_W-1:0] cdb1_dest;
  logic [DATA_W-1:0] cdb1_data;
  logic [1:0]        cdb1_src;

  // Producers and bus consumers side
  modport master (
    output src_valid, src_tag, src_dest, src_data,
    input  src_ready,
    input  cdb0_valid, cdb0_tag, cdb0_dest, cdb0_data, cdb0_src,
    input  cdb1_valid, cdb1_tag, cdb1_dest, cdb1_data, cdb1_src
  );

  // Arbiter side
  modport slave (
    input  src_valid, src_tag, src_dest, src_data,
    output src_ready,
    output cdb0_valid, cdb0_tag, cdb0_dest, cdb0_data, cdb0_src,
    output cdb1_valid, cdb1_tag, cdb1_dest, cdb1_data, cdb1_src
  );

endinterface

// File: rtl/cdb_src_fifo.sv
// rtl/cdb_src_fifo.sv - 2-entry per-producer result FIFO with flush
module cdb_src_fifo
  import cdb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_flush,
  input  logic       i_push,
  input  cdb_entry_t i_din,
  input  logic       i_pop,
  output logic [1:0] o_count,
  output cdb_entry_t o_head
);

  cdb_entry_t r_mem [2];
  logic       r_wptr;
  logic       r_rptr;
  logic [1:0] r_count;
  logic       w_push;
  logic       w_pop;

  // A full FIFO refuses pushes even when it pops in the same cycle.
  assign w_push = i_push && (r_count != 2'd2);
  assign w_pop  = i_pop && (r_count != 2'd0);

  // Pointers and occupancy; reset outranks flush, flush drops same-cycle pushes.
  always_ff @(posedge clk) begin
    if (!rst || i_flush) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  // Payload storage needs no reset; occupancy gates its visibility.
  always_ff @(posedge clk) begin
    if (rst && !i_flush && w_push) r_mem[r_wptr] <= i_din;
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rptr];

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - oldest-first dual CDB writeback arbiter; optional same-cycle bypass under CDB_BYPASS_EN
module cdb_arbiter
  import cdb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [TAG_W-1:0] commit_p,
  cdb_arbiter_if.slave     bus
);

  logic [1:0]         w_count [NUM_SRC];
  cdb_entry_t         w_head  [NUM_SRC];
  cdb_entry_t         w_in    [NUM_SRC];
  cdb_entry_t         w_cand  [NUM_SRC];
  logic [TAG_W-1:0]   w_age   [NUM_SRC];
  logic [NUM_SRC-1:0] w_ready;
  logic [NUM_SRC-1:0] w_byp;
  logic [NUM_SRC-1:0] w_cv;
  logic [NUM_SRC-1:0] w_grant;
  logic [NUM_SRC-1:0] w_push;
  logic [NUM_SRC-1:0] w_pop;
  logic               w_v0;
  logic               w_v1;
  logic [1:0]         w_s0;
  logic [1:0]         w_s1;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign w_in[g] = {bus.src_tag[g*TAG_W +: TAG_W],
                      bus.src_dest[g*DEST_W +: DEST_W],
                      bus.src_data[g*DATA_W +: DATA_W]};

    assign w_ready[g] = (w_count[g] != 2'd2);

`ifdef CDB_BYPASS_EN
    // An empty FIFO lets the arriving result compete directly.
    assign w_byp[g] = (w_count[g] == 2'd0) && bus.src_valid[g] && !flush;
`else
    assign w_byp[g] = 1'b0;
`endif

    assign w_cv[g]   = (w_count[g] != 2'd0) || w_byp[g];
    assign w_cand[g] = (w_count[g] != 2'd0) ? w_head[g] : w_in[g];
    assign w_age[g]  = cdb_age(w_cand[g].tag, commit_p);

    // A bypassed result that wins a bus never lands in the FIFO.
    assign w_pop[g]  = w_grant[g] && (w_count[g] != 2'd0);
    assign w_push[g] = bus.src_valid[g] && w_ready[g] && !(w_byp[g] && w_grant[g]);

    cdb_src_fifo u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_flush (flush),
      .i_push  (w_push[g]),
      .i_din   (w_in[g]),
      .i_pop   (w_pop[g]),
      .o_count (w_count[g]),
      .o_head  (w_head[g])
    );
  end

  // Two-winner oldest-first pick; strict compare leaves ties with the lower index.
  always_comb begin
    w_v0 = 1'b0;
    w_s0 = 2'd0;
    w_v1 = 1'b0;
    w_s1 = 2'd0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_cv[i] && (!w_v0 || (w_age[i] < w_age[w_s0]))) begin
        w_v0 = 1'b1;
        w_s0 = 2'(i);
      end
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_cv[i] && !(w_v0 && (w_s0 == 2'(i))) &&
          (!w_v1 || (w_age[i] < w_age[w_s1]))) begin
        w_v1 = 1'b1;
        w_s1 = 2'(i);
      end
    end
  end

  assign w_grant = (w_v0 ? (NUM_SRC'(1) << w_s0) : '0) |
                   (w_v1 ? (NUM_SRC'(1) << w_s1) : '0);

  assign bus.src_ready = w_ready;

  // Buses are zeroed whenever they carry nothing.
  assign bus.cdb0_valid = w_v0;
  assign bus.cdb0_src   = w_v0 ? w_s0 : 2'd0;
  assign bus.cdb0_tag   = w_v0 ? w_cand[w_s0].tag  : '0;
  assign bus.cdb0_dest  = w_v0 ? w_cand[w_s0].dest : '0;
  assign bus.cdb0_data  = w_v0 ? w_cand[w_s0].data : '0;

  assign bus.cdb1_valid = w_v1;
  assign bus.cdb1_src   = w_v1 ? w_s1 : 2'd0;
  assign bus.cdb1_tag   = w_v1 ? w_cand[w_s1].tag  : '0;
  assign bus.cdb1_dest  = w_v1 ? w_cand[w_s1].dest : '0;
  assign bus.cdb1_data  = w_v1 ? w_cand[w_s1].data : '0;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - scoreboard bench for cdb_arbiter
module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int WW = 1 + 2 + TAG_W + DEST_W + DATA_W;
  typedef logic [WW-1:0] word_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             flush = 1'b0;
  logic [TAG_W-1:0] commit_p = '0;

  cdb_arbiter_if bus();

  cdb_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .commit_p (commit_p),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_fail = 0;
  word_t exp_q [$];
  word_t sq [NUM_SRC][$];

  function automatic logic [DEST_W-1:0] dest_of(input logic [TAG_W-1:0] tag);
    return tag ^ 5'h15;
  endfunction

  function automatic logic [DATA_W-1:0] data_of(input int s, input logic [TAG_W-1:0] tag);
    return 32'hD00D_0000 | (DATA_W'(s) << 8) | DATA_W'(tag);
  endfunction

  function automatic word_t mk_word(input int s, input logic [TAG_W-1:0] tag);
    return {1'b1, 2'(s), tag, dest_of(tag), data_of(s, tag)};
  endfunction

  function automatic word_t obs(input int b);
    if (b == 0)
      return {bus.cdb0_valid, bus.cdb0_src, bus.cdb0_tag, bus.cdb0_dest, bus.cdb0_data};
    return {bus.cdb1_valid, bus.cdb1_src, bus.cdb1_tag, bus.cdb1_dest, bus.cdb1_data};
  endfunction

  function automatic word_t pop_exp();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  task automatic idle_inputs();
    bus.src_valid = '0;
    bus.src_tag   = '0;
    bus.src_dest  = '0;
    bus.src_data  = '0;
    flush         = 1'b0;
  endtask

  task automatic drive_src(input int i, input logic [TAG_W-1:0] tag);
    bus.src_valid[i]                = 1'b1;
    bus.src_tag[i*TAG_W +: TAG_W]   = tag;
    bus.src_dest[i*DEST_W +: DEST_W] = dest_of(tag);
    bus.src_data[i*DATA_W +: DATA_W] = data_of(i, tag);
  endtask

  task automatic test_reset();
    word_t got;
    idle_inputs();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    n_checks++;
    if (bus.src_ready !== 4'b1111) begin n_fail++; $display("FAIL rst_ready: got %b want 1111", bus.src_ready); end
    got = obs(0); n_checks++;
    if (got !== '0) begin n_fail++; $display("FAIL rst_cdb0: got %h want 0", got); end
    got = obs(1); n_checks++;
    if (got !== '0) begin n_fail++; $display("FAIL rst_cdb1: got %h want 0", got); end
    rst = 1'b1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.src_ready !== 4'b1111) begin n_fail++; $display("FAIL idle_flush_ready: got %b want 1111", bus.src_ready); end
    got = obs(0); n_checks++;
    if (got !== '0) begin n_fail++; $display("FAIL idle_flush_cdb0: got %h want 0", got); end
    @(posedge clk); #1;
  endtask

  task automatic test_priority();
    word_t got, want;
    commit_p = 5'd5;
    drive_src(SRC_ALU1, 5'd7);
    drive_src(SRC_ALU2, 5'd9);
    drive_src(SRC_LD1, 5'd6);
    exp_q.push_back(mk_word(SRC_LD1, 5'd6));
    exp_q.push_back(mk_word(SRC_ALU1, 5'd7));
    exp_q.push_back(mk_word(SRC_ALU2, 5'd9));
    @(negedge clk);
    got = obs(0); n_checks++;
    if (got !== '0) begin n_fail++; $display("FAIL prio_push_cycle_cdb0: got %h want 0", got); end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    got = obs(0); want = pop_exp(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL prio_c1_cdb0: got %h want %h", got, want); end
    got = obs(1); want = pop_exp(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL prio_c1_cdb1: got %h want %h", got, want); end
    @(posedge clk); #1;
    @(negedge clk);
    got = obs(0); want = pop_exp(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL prio_c2_cdb0: got %h want %h", got, want); end
    got = obs(1); n_checks++;
    if (got !== '0) begin n_fail++; $display("FAIL prio_c2_cdb1: got %h want 0", got); end
    @(posedge clk); #1;
    @(negedge clk);
    got = obs(0); n_checks++;
    if (got !== '0) begin n_fail++; $display("FAIL prio_drained: got %h want 0", got); end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap();
    word_t got, want;
    commit_p = 5'd30;
    drive_src(SRC_ALU1, 5'd1);
    drive_src(SRC_LD2, 5'd31);
    exp_q.push_back(mk_word(SRC_LD2, 5'd31));
    exp_q.push_back(mk_word(SRC_ALU1, 5'd1));
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    got = obs(0); want = pop_exp(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL wrap_cdb0: got %h want %h", got, want); end
    got = obs(1); want = pop_exp(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL wrap_cdb1: got %h want %h", got, want); end
    @(posedge clk); #1;
  endtask

  task automatic test_tie();
    word_t got, want;
    commit_p = 5'd0;
    drive_src(SRC_ALU2, 5'd4);
    drive_src(SRC_LD1, 5'd4);
    exp_q.push_back(mk_word(SRC_ALU2, 5'd4));
    exp_q.push_back(mk_word(SRC_LD1, 5'd4));
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    got = obs(0); want = pop_exp(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL tie_cdb0: got %h want %h", got, want); end
    got = obs(1); want = pop_exp(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL tie_cdb1: got %h want %h", got, want); end
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL tie_leftover: got %0d want 0", exp_q.size()); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int    nj [NUM_SRC];
    int    mc [NUM_SRC];
    bit    saw_full [NUM_SRC];
    bit    acc [NUM_SRC];
    bit    gr [NUM_SRC];
    bit    done;
    word_t got, want;
    logic [TAG_W-1:0] a0, a1;
    int    s;
    commit_p = 5'd0;
    done = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin nj[i] = 0; mc[i] = 0; saw_full[i] = 1'b0; end
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (nj[i] < 4) drive_src(i, TAG_W'(4 * nj[i] + i));
        else bus.src_valid[i] = 1'b0;
      end
      @(negedge clk);
      for (int i = 0; i < NUM_SRC; i++) begin
        n_checks++;
        if (bus.src_ready[i] !== (mc[i] < 2)) begin
          n_fail++; $display("FAIL b2b_ready%0d: got %b want %b", i, bus.src_ready[i], (mc[i] < 2));
        end
        if (bus.src_ready[i] === 1'b0) saw_full[i] = 1'b1;
        acc[i] = bus.src_valid[i] && bus.src_ready[i];
        gr[i]  = 1'b0;
        if (acc[i]) sq[i].push_back(mk_word(i, TAG_W'(4 * nj[i] + i)));
      end
      for (int b = 0; b < 2; b++) begin
        got = obs(b);
        if (got[WW-1]) begin
          s = int'(got[WW-2 -: 2]);
          want = (sq[s].size() != 0) ? sq[s].pop_front() : 'x;
          gr[s] = 1'b1;
          n_checks++;
          if (got !== want) begin n_fail++; $display("FAIL b2b_grant_cdb%0d: got %h want %h", b, got, want); end
        end
      end
      if (bus.cdb0_valid && bus.cdb1_valid) begin
        a0 = cdb_age(bus.cdb0_tag, commit_p);
        a1 = cdb_age(bus.cdb1_tag, commit_p);
        n_checks++;
        if (a0 > a1 || (a0 == a1 && bus.cdb0_src > bus.cdb1_src)) begin
          n_fail++; $display("FAIL b2b_order: got ages %0d,%0d want cdb0 not younger", a0, a1);
        end
      end
      for (int i = 0; i < NUM_SRC; i++) begin
        mc[i] = mc[i] + int'(acc[i]) - int'(gr[i]);
        if (acc[i]) nj[i]++;
      end
      @(posedge clk); #1;
      done = 1'b1;
      for (int i = 0; i < NUM_SRC; i++) if (nj[i] < 4 || sq[i].size() != 0) done = 1'b0;
    end
    idle_inputs();
    n_checks++;
    if (!done) begin n_fail++; $display("FAIL b2b_timeout: got incomplete drain want all 16 granted"); end
    for (int i = 0; i < NUM_SRC; i++) begin
      n_checks++;
      if (saw_full[i] !== 1'b1) begin n_fail++; $display("FAIL b2b_backpressure%0d: got never-low want low once", i); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    word_t got;
    commit_p = 5'd0;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < NUM_SRC; i++) drive_src(i, TAG_W'(16 + 4 * k + i));
      @(posedge clk); #1;
    end
    for (int i = 0; i < NUM_SRC; i++) drive_src(i, TAG_W'(28 + i));
    flush = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.src_ready === 4'b1111) begin n_fail++; $display("FAIL flush_pre_full: got %b want some low", bus.src_ready); end
    n_checks++;
    if (bus.cdb0_valid !== 1'b1) begin n_fail++; $display("FAIL flush_cycle_cdb0_valid: got %b want 1", bus.cdb0_valid); end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if (bus.src_ready !== 4'b1111) begin n_fail++; $display("FAIL flush_ready: got %b want 1111", bus.src_ready); end
    got = obs(0); n_checks++;
    if (got !== '0) begin n_fail++; $display("FAIL flush_stale_cdb0: got %h want 0", got); end
    got = obs(1); n_checks++;
    if (got !== '0) begin n_fail++; $display("FAIL flush_stale_cdb1: got %h want 0", got); end
    @(posedge clk); #1;
    @(negedge clk);
    got = obs(0); n_checks++;
    if (got !== '0) begin n_fail++; $display("FAIL flush_after_cdb0: got %h want 0", got); end
    @(posedge clk); #1;
  endtask

`ifdef CDB_BYPASS_EN
  task automatic test_bypass();
    word_t got, want;
    commit_p = 5'd0;
    drive_src(SRC_ALU1, 5'd3);
    exp_q.push_back(mk_word(SRC_ALU1, 5'd3));
    @(negedge clk);
    got = obs(0); want = pop_exp(); n_checks++;
    if (got !== want) begin n_fail++; $display("FAIL bypass_cdb0: got %h want %h", got, want); end
    got = obs(1); n_checks++;
    if (got !== '0) begin n_fail++; $display("FAIL bypass_cdb1: got %h want 0", got); end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    got = obs(0); n_checks++;
    if (got !== '0) begin n_fail++; $display("FAIL bypass_fifo_empty: got %h want 0", got); end
    n_checks++;
    if (bus.src_ready !== 4'b1111) begin n_fail++; $display("FAIL bypass_ready: got %b want 1111", bus.src_ready); end
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    test_reset();
`ifndef CDB_BYPASS_EN
    test_priority();
    test_wrap();
    test_tie();
`endif
    test_back_to_back();
    test_flush();
`ifdef CDB_BYPASS_EN
    test_bypass();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
